// File: rtl/fp_mult_result_queue.sv
// rtl/fp_mult_result_queue.sv - result FIFO with sticky exception flags for the fp multiplier
//
// Buffers multiplier product words and their status bytes in a
// first-word-fall-through FIFO, and accumulates sticky status plus
// saturating event counters for software.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready/in_z/in_status      producer side (push)
//   out_valid/out_ready/out_z/out_status  consumer side (pop), zero when empty
//   level                         occupancy 0..DEPTH
//   sticky_status, sticky_clr     OR of accepted statuses, synchronous clear
//   nan_count, inexact_count, ovf_unf_count  saturating event counters
//
// Status byte: {overflow, underflow, zero, inf, nan, tiny, huge, inexact}.

module fp_mult_result_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_z,
  input  logic [7:0]                 in_status,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_z,
  output logic [7:0]                 out_status,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 sticky_status,
  input  logic                       sticky_clr,
  output logic [CNT_W-1:0]           nan_count,
  output logic [CNT_W-1:0]           inexact_count,
  output logic [CNT_W-1:0]           ovf_unf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [31:0]   z_mem [DEPTH];
  logic [7:0]    s_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          push;
  logic          pop;

  // Handshake flags come only from the registered level, so back-pressure
  // never ripples combinationally between producer and consumer.
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = level_q;

  // Head is read straight from storage; gated to zero while empty.
  assign out_z      = out_valid ? z_mem[rd_ptr] : 32'd0;
  assign out_status = out_valid ? s_mem[rd_ptr] : 8'd0;

  // Storage carries no reset; contents are only observable when valid.
  always_ff @(posedge clk) begin
    if (push) begin
      z_mem[wr_ptr] <= in_z;
      s_mem[wr_ptr] <= in_status;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Clear takes effect first, then the same-cycle push is accumulated.
  function automatic logic [CNT_W-1:0] cnt_next(
    input logic [CNT_W-1:0] cnt,
    input logic             hit,
    input logic             clr
  );
    logic [CNT_W-1:0] base;
    base = clr ? '0 : cnt;
    if (hit && (base != '1)) return base + CNT_W'(1);
    return base;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_status <= '0;
      nan_count     <= '0;
      inexact_count <= '0;
      ovf_unf_count <= '0;
    end else begin
      if (sticky_clr)
        sticky_status <= push ? in_status : 8'd0;
      else if (push)
        sticky_status <= sticky_status | in_status;
      nan_count     <= cnt_next(nan_count,     push && in_status[3], sticky_clr);
      inexact_count <= cnt_next(inexact_count, push && in_status[0], sticky_clr);
      ovf_unf_count <= cnt_next(ovf_unf_count, push && (in_status[7] || in_status[6]), sticky_clr);
    end
  end

endmodule

// File: tb/tb_fp_mult_result_queue.sv
// tb/tb_fp_mult_result_queue.sv - directed self-checking bench for fp_mult_result_queue

module tb_fp_mult_result_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_z;
  logic [7:0]        in_status;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_z;
  logic [7:0]        out_status;
  logic [2:0]        level;
  logic [7:0]        sticky_status;
  logic              sticky_clr;
  logic [CNT_W-1:0]  nan_count;
  logic [CNT_W-1:0]  inexact_count;
  logic [CNT_W-1:0]  ovf_unf_count;

  int n_vec = 0;
  int n_bad = 0;

  fp_mult_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_z          (in_z),
    .in_status     (in_status),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_z         (out_z),
    .out_status    (out_status),
    .level         (level),
    .sticky_status (sticky_status),
    .sticky_clr    (sticky_clr),
    .nan_count     (nan_count),
    .inexact_count (inexact_count),
    .ovf_unf_count (ovf_unf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words [5];
  logic [31:0] exp_head;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_z       = 32'd0;
    in_status  = 8'd0;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
    for (int i = 0; i < 5; i++) words[i] = 32'h1000_0000 + 32'(i) * 32'h0101;

    // reset state
    step();
    chk("rst_level",   32'(level), 32'd0);
    chk("rst_in_rdy",  32'(in_ready), 32'd1);
    chk("rst_out_vld", 32'(out_valid), 32'd0);
    chk("rst_out_z",   out_z, 32'd0);
    chk("rst_out_st",  32'(out_status), 32'd0);
    chk("rst_sticky",  32'(sticky_status), 32'd0);
    chk("rst_inexact", 32'(inexact_count), 32'd0);
    rst_n = 1'b1;
    step();

    // single push, fall-through with 1-cycle latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_z = 32'h40490FDB; in_status = 8'h01;
    step();
    in_valid = 1'b0;
    chk("t1_out_vld", 32'(out_valid), 32'd1);
    chk("t1_out_z",   out_z, 32'h40490FDB);
    chk("t1_out_st",  32'(out_status), 32'h01);
    chk("t1_level",   32'(level), 32'd1);
    chk("t1_inexact", 32'(inexact_count), 32'd1);
    step();
    chk("t1_level_pop", 32'(level), 32'd0);
    chk("t1_vld_pop",   32'(out_valid), 32'd0);
    chk("t1_z_empty",   out_z, 32'd0);

    // fill to full, fifth word held until a pop
    out_ready = 1'b0;
    in_status = 8'h00;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_z = words[i];
      step();
    end
    chk("t2_level_full", 32'(level), 32'd4);
    chk("t2_in_rdy",     32'(in_ready), 32'd0);
    in_z = words[4];
    step();
    chk("t2_level_held", 32'(level), 32'd4);
    chk("t2_head0",      out_z, words[0]);
    out_ready = 1'b1;
    step();
    chk("t2_level_pop1", 32'(level), 32'd3);
    chk("t2_head1",      out_z, words[1]);
    step();
    in_valid = 1'b0;
    chk("t2_level_pp",   32'(level), 32'd3);
    for (int i = 2; i < 5; i++) begin
      chk($sformatf("t2_drain%0d", i), out_z, words[i]);
      step();
    end
    chk("t2_level_end", 32'(level), 32'd0);

    // streaming at level 2 across pointer wrap
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_z = 32'hA000_0001; step();
    in_z = 32'hB000_0002; step();
    chk("t3_level_start", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_z = 32'h2000_0000 + 32'(k);
      if (k == 0)      exp_head = 32'hA000_0001;
      else if (k == 1) exp_head = 32'hB000_0002;
      else             exp_head = 32'h2000_0000 + 32'(k - 2);
      chk($sformatf("t3_head%0d", k), out_z, exp_head);
      step();
      chk($sformatf("t3_level%0d", k), 32'(level), 32'd2);
    end
    in_valid = 1'b0;
    chk("t3_tail18", out_z, 32'h2000_0012);
    step();
    chk("t3_tail19", out_z, 32'h2000_0013);
    step();
    chk("t3_level_end", 32'(level), 32'd0);

    // sticky flags and counters, clear alone then clear with push
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("t4_clr_inexact", 32'(inexact_count), 32'd0);
    in_valid = 1'b1;
    in_status = 8'h08; step();
    in_status = 8'h80; step();
    in_status = 8'h40; step();
    in_valid = 1'b0;
    chk("t4_sticky", 32'(sticky_status), 32'hC8);
    chk("t4_nan",    32'(nan_count), 32'd1);
    chk("t4_ovfunf", 32'(ovf_unf_count), 32'd2);
    sticky_clr = 1'b1; in_valid = 1'b1; in_status = 8'h08;
    step();
    sticky_clr = 1'b0; in_valid = 1'b0;
    chk("t4_clr_sticky", 32'(sticky_status), 32'h08);
    chk("t4_clr_nan",    32'(nan_count), 32'd1);
    chk("t4_clr_ovfunf", 32'(ovf_unf_count), 32'd0);
    step();

    // counter saturation at 2^CNT_W-1
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    in_status = 8'h01;
    for (int i = 1; i <= 20; i++) begin
      in_valid = 1'b1;
      step();
      if (i == 14) chk("t5_inexact14", 32'(inexact_count), 32'd14);
      if (i == 15) chk("t5_inexact15", 32'(inexact_count), 32'd15);
    end
    in_valid = 1'b0;
    chk("t5_inexact_sat", 32'(inexact_count), 32'd15);
    step();
    chk("t5_level_end", 32'(level), 32'd0);

    // asynchronous reset mid-burst
    out_ready = 1'b0;
    in_status = 8'h81;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_z = 32'h3000_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    chk("t6_level3",  32'(level), 32'd3);
    chk("t6_ovf3",    32'(ovf_unf_count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_level",  32'(level), 32'd0);
    chk("t6_rst_vld",    32'(out_valid), 32'd0);
    chk("t6_rst_sticky", 32'(sticky_status), 32'd0);
    chk("t6_rst_ovf",    32'(ovf_unf_count), 32'd0);
    chk("t6_rst_inex",   32'(inexact_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_z = 32'hCAFEF00D; in_status = 8'h02;
    step();
    in_valid = 1'b0;
    chk("t6_first_z",  out_z, 32'hCAFEF00D);
    chk("t6_first_st", 32'(out_status), 32'h02);
    chk("t6_level1",   32'(level), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
